// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-clock-enable divider, h/v counters and a
// drawer-latency-matched sync/blank/colour stage. Optional bar pattern: VGA_TIMING_TEST_PATTERN_EN.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int COORD_W  = 10,
   parameter int COLOR_W  = 4,
   parameter int PIPE     = 1
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic               pix_ce,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               isdisplayed,
   output logic               line_start,
   output logic               frame_start,
   input  logic [COLOR_W-1:0] r_in,
   input  logic [COLOR_W-1:0] g_in,
   input  logic [COLOR_W-1:0] b_in,
   input  logic               test_en,
   output logic               hsync,
   output logic               vsync,
   output logic [COLOR_W-1:0] red,
   output logic [COLOR_W-1:0] green,
   output logic [COLOR_W-1:0] blue
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_BEG  = H_ACTIVE + H_FP;
   localparam int HS_END  = HS_BEG + H_SYNC;
   localparam int VS_BEG  = V_ACTIVE + V_FP;
   localparam int VS_END  = VS_BEG + V_SYNC;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic HS_ACT = (HS_POL != 0);
   localparam logic VS_ACT = (VS_POL != 0);
`ifdef VGA_TIMING_TEST_PATTERN_EN
   localparam int DL_W = 6;
`else
   localparam int DL_W = 3;
`endif

   if (CLK_DIV < 1) begin : g_err_div
      $error("vga_timing_gen: CLK_DIV must be >= 1");
   end
   if (PIPE < 0) begin : g_err_pipe
      $error("vga_timing_gen: PIPE must be >= 0");
   end
   if ((H_TOTAL - 1) >= (2 ** COORD_W) || (V_TOTAL - 1) >= (2 ** COORD_W)) begin : g_err_coord
      $error("vga_timing_gen: H_TOTAL-1 / V_TOTAL-1 do not fit in COORD_W");
   end

   logic [DIV_W-1:0]   div_q, div_d;
   logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
   logic               hs_raw, vs_raw, de_raw;
   logic [DL_W-1:0]    dl_in, dl_out;
   logic               hsync_q, vsync_q;
   logic [COLOR_W-1:0] red_q, green_q, blue_q, r_d, g_d, b_d;

   assign pix_ce = (div_q == DIV_W'(CLK_DIV - 1));

   always_comb begin
      div_d = pix_ce ? '0 : div_q + DIV_W'(1);
      h_d   = h_q;
      v_d   = v_q;
      if (pix_ce) begin
         if (h_q == COORD_W'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == COORD_W'(V_TOTAL - 1)) ? '0 : v_q + COORD_W'(1);
         end else begin
            h_d = h_q + COORD_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
      end
   end

   assign x           = h_q;
   assign y           = v_q;
   assign de_raw      = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
   assign isdisplayed = de_raw;
   assign hs_raw      = (32'(h_q) >= HS_BEG) && (32'(h_q) < HS_END);
   assign vs_raw      = (32'(v_q) >= VS_BEG) && (32'(v_q) < VS_END);
   assign line_start  = pix_ce && (h_q == '0);
   assign frame_start = pix_ce && (h_q == '0) && (v_q == '0);

`ifdef VGA_TIMING_TEST_PATTERN_EN
   if (H_ACTIVE < 8) begin : g_err_bar
      $error("vga_timing_gen: H_ACTIVE must be >= 8 for the bar pattern");
   end
   logic [2:0] bar_raw;
   // Bar index travels with hs/vs/de so it lines up with the drawer's colour.
   always_comb begin
      bar_raw = 3'd7;
      if ((32'(h_q) / (H_ACTIVE / 8)) < 7) bar_raw = 3'(32'(h_q) / (H_ACTIVE / 8));
   end
   assign dl_in = {bar_raw, de_raw, vs_raw, hs_raw};
`else
   logic unused_test_en;
   assign unused_test_en = test_en;
   assign dl_in = {de_raw, vs_raw, hs_raw};
`endif

   if (PIPE > 0) begin : g_dl
      logic [PIPE-1:0][DL_W-1:0] dl_q;
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            dl_q <= '0;
         end else if (pix_ce) begin
            dl_q[0] <= dl_in;
            for (int i = 1; i < PIPE; i++) dl_q[i] <= dl_q[i-1];
         end
      end
      assign dl_out = dl_q[PIPE-1];
   end else begin : g_nodl
      assign dl_out = dl_in;
   end

   always_comb begin
      r_d = dl_out[2] ? r_in : '0;
      g_d = dl_out[2] ? g_in : '0;
      b_d = dl_out[2] ? b_in : '0;
`ifdef VGA_TIMING_TEST_PATTERN_EN
      if (test_en && dl_out[2]) begin
         r_d = {COLOR_W{dl_out[5]}};
         g_d = {COLOR_W{dl_out[4]}};
         b_d = {COLOR_W{dl_out[3]}};
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hsync_q <= ~HS_ACT;
         vsync_q <= ~VS_ACT;
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
      end else if (pix_ce) begin
         hsync_q <= dl_out[0] ~^ HS_ACT;
         vsync_q <= dl_out[1] ~^ VS_ACT;
         red_q   <= r_d;
         green_q <= g_d;
         blue_q  <= b_d;
      end
   end

   assign hsync = hsync_q;
   assign vsync = vsync_q;
   assign red   = red_q;
   assign green = green_q;
   assign blue  = blue_q;

endmodule
